// File: rtl/sign_extend_arbiter_pkg.sv
// sign_extend_arbiter_pkg
// Shared definitions for the two-requester sign/zero-extension block:
//   - default datapath and position-code widths
//   - position-code constants (which bit the extension field ends at)
//   - requester-id type
//   - pos_to_bit(): maps a position code to the field width in bits
package sign_extend_arbiter_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned POS_W_DEF = 3;

    // Position codes. The field kept is data[P-1:0]; bit P-1 is the sign bit.
    localparam int unsigned POS_BYTE  = 0;  // P = 8
    localparam int unsigned POS_IMM12 = 1;  // P = 12
    localparam int unsigned POS_IMM13 = 2;  // P = 13
    localparam int unsigned POS_HALF  = 3;  // P = 16
    localparam int unsigned POS_IMM21 = 4;  // P = 21
    localparam int unsigned POS_FULL  = 5;  // 5..7 all mean full width

    typedef enum logic {
        ReqId0 = 1'b0,
        ReqId1 = 1'b1
    } req_id_t;

    // Field width for a position code; anything at or above POS_FULL means the
    // whole word passes through untouched.
    function automatic int unsigned pos_to_bit(input int unsigned code,
                                               input int unsigned xlen);
        int unsigned bit_pos;
        case (code)
            POS_BYTE:  bit_pos = 8;
            POS_IMM12: bit_pos = 12;
            POS_IMM13: bit_pos = 13;
            POS_HALF:  bit_pos = 16;
            POS_IMM21: bit_pos = 21;
            default:   bit_pos = xlen;
        endcase
        if (bit_pos > xlen) begin
            bit_pos = xlen;
        end
        return bit_pos;
    endfunction

endpackage

// File: rtl/sign_extend_arbiter_if.sv
// sign_extend_arbiter_if
// Bundles the two requester channels and the response channel.
//   req0_* : decode-stage immediates (valid/data/pos/sext in, ready out of DUT)
//   req1_* : load-unit data          (valid/data/pos/sext in, ready out of DUT)
//   resp_* : registered result       (valid/data/id out of DUT, ready into DUT)
// Modports:
//   slave  : the arbiter itself
//   master : the surroundings (requesters plus result consumer)
interface sign_extend_arbiter_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned POS_W = 3
) ();

    logic             req0_valid;
    logic [XLEN-1:0]  req0_data;
    logic [POS_W-1:0] req0_pos;
    logic             req0_sext;
    logic             req0_ready;

    logic             req1_valid;
    logic [XLEN-1:0]  req1_data;
    logic [POS_W-1:0] req1_pos;
    logic             req1_sext;
    logic             req1_ready;

    logic             resp_valid;
    logic [XLEN-1:0]  resp_data;
    logic             resp_id;
    logic             resp_ready;

    modport slave (
        input  req0_valid, req0_data, req0_pos, req0_sext,
        input  req1_valid, req1_data, req1_pos, req1_sext,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_data, resp_id
    );

    modport master (
        output req0_valid, req0_data, req0_pos, req0_sext,
        output req1_valid, req1_data, req1_pos, req1_sext,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_data, resp_id
    );

endinterface

// File: rtl/sign_extend_arbiter_var_sign_extend.sv
// var_sign_extend
// Combinational variable-position sign/zero extension.
//   i_data   : raw value; bits at and above the selected position are ignored
//   i_pos    : position code (see sign_extend_arbiter_pkg)
//   i_sext   : 1 = replicate field MSB upward, 0 = clear upper bits
//   o_result : extended value (full-width codes pass i_data through)
module var_sign_extend
    import sign_extend_arbiter_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned POS_W = POS_W_DEF
) (
    input  logic [XLEN-1:0]  i_data,
    input  logic [POS_W-1:0] i_pos,
    input  logic             i_sext,
    output logic [XLEN-1:0]  o_result
);

    int unsigned     w_bit;
    logic [XLEN-1:0] w_keep_mask;  // ones over the kept field
    logic [XLEN-1:0] w_sign_sel;   // one-hot at the field MSB (empty for full width)
    logic            w_sign;

    always_comb begin
        w_bit       = pos_to_bit(32'(i_pos), XLEN);
        w_keep_mask = '0;
        w_sign_sel  = '0;
        for (int i = 0; i < XLEN; i++) begin
            w_keep_mask[i] = (32'(i) < w_bit);
            // Full width leaves w_sign_sel empty, so sext has no effect there.
            w_sign_sel[i]  = (32'(i) + 32'd1 == w_bit) && (w_bit < XLEN);
        end
        w_sign   = |(i_data & w_sign_sel);
        o_result = (i_data & w_keep_mask) | (~w_keep_mask & {XLEN{i_sext & w_sign}});
    end

endmodule

// File: rtl/sign_extend_arbiter.sv
// sign_extend_arbiter
// Shares one var_sign_extend datapath between two requesters with round-robin
// arbitration and a single registered result stage.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sign_extend_arbiter_if.slave
//           req0_*/req1_* valid/ready operand channels, resp_* result channel
// Latency is one cycle; the result register reloads in the same cycle it is
// drained, so back-to-back results flow at one per cycle.
module sign_extend_arbiter
    import sign_extend_arbiter_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned POS_W = POS_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sign_extend_arbiter_if.slave  bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            r_resp_valid;
    logic [XLEN-1:0] r_resp_data;
    req_id_t         r_resp_id;
    req_id_t         r_last_grant;

    // ------------------------------------------------------------------
    // Arbitration and handshake
    // ------------------------------------------------------------------
    logic             w_out_free;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_ready0;
    logic             w_ready1;
    logic             w_accept;
    req_id_t          w_sel;
    logic [XLEN-1:0]  w_mux_data;
    logic [POS_W-1:0] w_mux_pos;
    logic             w_mux_sext;
    logic [XLEN-1:0]  w_ext_result;

    always_comb begin
        w_out_free = !r_resp_valid || bus.resp_ready;

        // On contention the requester that did not win last time goes next.
        w_grant0 = bus.req0_valid && (!bus.req1_valid || (r_last_grant == ReqId1));
        w_grant1 = bus.req1_valid && (!bus.req0_valid || (r_last_grant == ReqId0));

        // Readies are held low while in reset so nothing is handed off then.
        w_ready0 = w_grant0 && w_out_free && rst_n;
        w_ready1 = w_grant1 && w_out_free && rst_n;
        w_accept = w_ready0 || w_ready1;

        w_sel = w_grant1 ? ReqId1 : ReqId0;

        w_mux_data = bus.req0_data;
        w_mux_pos  = bus.req0_pos;
        w_mux_sext = bus.req0_sext;
        if (w_sel == ReqId1) begin
            w_mux_data = bus.req1_data;
            w_mux_pos  = bus.req1_pos;
            w_mux_sext = bus.req1_sext;
        end
    end

    var_sign_extend #(
        .XLEN  (XLEN),
        .POS_W (POS_W)
    ) u_var_sign_extend (
        .i_data   (w_mux_data),
        .i_pos    (w_mux_pos),
        .i_sext   (w_mux_sext),
        .o_result (w_ext_result)
    );

    // ------------------------------------------------------------------
    // Result register and last-grant tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= ReqId0;
            r_last_grant <= ReqId1;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_ext_result;
            r_resp_id    <= w_sel;
            r_last_grant <= w_sel;
        end else if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_id    = r_resp_id;

    // ------------------------------------------------------------------
    // Protocol checks: requesters must hold valid and payload until ready.
    // ------------------------------------------------------------------
    a_req0_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (bus.req0_valid && !bus.req0_ready) |=>
            (bus.req0_valid && $stable(bus.req0_data) &&
             $stable(bus.req0_pos) && $stable(bus.req0_sext)));

    a_req1_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (bus.req1_valid && !bus.req1_ready) |=>
            (bus.req1_valid && $stable(bus.req1_data) &&
             $stable(bus.req1_pos) && $stable(bus.req1_sext)));

    a_one_ready : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.req0_ready && bus.req1_ready));

endmodule

// File: tb/tb_sign_extend_arbiter.sv
// tb_sign_extend_arbiter
// Directed stimulus with hand-computed expectations, plus a transaction-level
// model compared against the DUT on every falling clock edge.
module tb_sign_extend_arbiter;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_bad;

    sign_extend_arbiter_if #(.XLEN(32), .POS_W(3)) bus ();

    sign_extend_arbiter #(.XLEN(32), .POS_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Extension computed arithmetically: keep data mod 2^P, and for sext treat
    // a field at or above 2^(P-1) as negative.
    function automatic logic [31:0] ext_model(input logic [31:0] d, input int code,
                                              input bit s);
        int     p;
        longint f;
        case (code)
            0: p = 8;
            1: p = 12;
            2: p = 13;
            3: p = 16;
            4: p = 21;
            default: p = 32;
        endcase
        if (p == 32) return d;
        f = longint'(d) % (longint'(1) << p);
        if (s && (f >= (longint'(1) << (p - 1)))) f = f - (longint'(1) << p);
        return f[31:0];
    endfunction

    // Which requester should be granted: -1 = none.
    function automatic int who_wins(input bit v0, input bit v1, input bit last);
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // ------------------------------------------------------------------
    // Model state
    // ------------------------------------------------------------------
    bit          m_valid = 1'b0;
    logic [31:0] m_data  = 32'h0;
    bit          m_id    = 1'b0;
    bit          m_last  = 1'b1;

    function automatic bit m_free();
        return !m_valid || bus.resp_ready;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 32'h0;
            m_id    <= 1'b0;
            m_last  <= 1'b1;
        end else if (m_free() && who_wins(bus.req0_valid, bus.req1_valid, m_last) >= 0) begin
            m_valid <= 1'b1;
            m_id    <= (who_wins(bus.req0_valid, bus.req1_valid, m_last) == 1);
            m_last  <= (who_wins(bus.req0_valid, bus.req1_valid, m_last) == 1);
            if (who_wins(bus.req0_valid, bus.req1_valid, m_last) == 1)
                m_data <= ext_model(bus.req1_data, int'(bus.req1_pos), bus.req1_sext);
            else
                m_data <= ext_model(bus.req0_data, int'(bus.req0_pos), bus.req0_sext);
        end else if (bus.resp_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Compare process.
    always @(negedge clk) begin
        chk("m_resp_valid", 32'(bus.resp_valid), 32'(m_valid));
        chk("m_req0_ready", 32'(bus.req0_ready),
            32'(rst_n && m_free() && who_wins(bus.req0_valid, bus.req1_valid, m_last) == 0));
        chk("m_req1_ready", 32'(bus.req1_ready),
            32'(rst_n && m_free() && who_wins(bus.req0_valid, bus.req1_valid, m_last) == 1));
        if (m_valid) begin
            chk("m_resp_data", bus.resp_data, m_data);
            chk("m_resp_id", 32'(bus.resp_id), 32'(m_id));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic one_shot(input int id, input logic [31:0] d, input logic [2:0] p,
                            input bit s, input logic [31:0] exp, input string name);
        step();
        if (id == 0) begin
            bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_pos = p; bus.req0_sext = s;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_pos = p; bus.req1_sext = s;
        end
        @(negedge clk);
        chk({name, "_ready"}, 32'((id == 0) ? bus.req0_ready : bus.req1_ready), 32'd1);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({name, "_data"}, bus.resp_data, exp);
        chk({name, "_id"}, 32'(bus.resp_id), 32'(id));
    endtask

    logic [31:0] rr_ids  [4];
    logic [31:0] rr_data [4];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_pos = '0; bus.req0_sext = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_pos = '0; bus.req1_sext = 1'b0;
        bus.resp_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_data", bus.resp_data, 32'h0);
        chk("rst_id", 32'(bus.resp_id), 32'd0);
        chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
        step();
        rst_n = 1'b1;

        // Single-requester vectors.
        one_shot(0, 32'h0000_0800, 3'd1, 1'b1, 32'hFFFF_F800, "imm12_neg");
        one_shot(1, 32'hFFFF_FF80, 3'd0, 1'b0, 32'h0000_0080, "byte_zext");
        one_shot(1, 32'hFFFF_FF80, 3'd0, 1'b1, 32'hFFFF_FF80, "byte_sext");
        one_shot(1, 32'h1234_5678, 3'd5, 1'b0, 32'h1234_5678, "full_zext");
        one_shot(1, 32'h1234_5678, 3'd5, 1'b1, 32'h1234_5678, "full_sext");
        one_shot(0, 32'h0000_1000, 3'd2, 1'b1, 32'hFFFF_F000, "imm13_neg");
        one_shot(0, 32'h0010_0000, 3'd4, 1'b1, 32'hFFF0_0000, "imm21_neg");
        one_shot(0, 32'h0000_7FFF, 3'd3, 1'b1, 32'h0000_7FFF, "half_pos");
        one_shot(1, 32'hABCD_E123, 3'd7, 1'b1, 32'hABCD_E123, "code7");

        // Round robin after reset: both valid every cycle.
        step();
        rst_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_data = 32'h0000_00FF; bus.req0_pos = 3'd0;
        bus.req0_sext = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_data = 32'h0000_007F; bus.req1_pos = 3'd0;
        bus.req1_sext = 1'b1;
        step();
        rst_n = 1'b1;
        rr_ids[0] = 32'd0; rr_ids[1] = 32'd1; rr_ids[2] = 32'd0; rr_ids[3] = 32'd1;
        rr_data[0] = 32'hFFFF_FFFF; rr_data[1] = 32'h0000_007F;
        rr_data[2] = 32'hFFFF_FFFF; rr_data[3] = 32'h0000_007F;
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_valid", 32'(bus.resp_valid), 32'd1);
            chk("rr_id", 32'(bus.resp_id), rr_ids[k]);
            chk("rr_data", bus.resp_data, rr_data[k]);
            step();
        end

        // Backpressure: result from requester 0 must stay put.
        bus.resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_id", 32'(bus.resp_id), 32'd0);
            chk("bp_data", bus.resp_data, 32'hFFFF_FFFF);
            chk("bp_ready0", 32'(bus.req0_ready), 32'd0);
            chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
            step();
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_ready1", 32'(bus.req1_ready), 32'd1);
        chk("bp_rel_ready0", 32'(bus.req0_ready), 32'd0);
        step();
        @(negedge clk);
        chk("bp_next_valid", 32'(bus.resp_valid), 32'd1);
        chk("bp_next_id", 32'(bus.resp_id), 32'd1);
        chk("bp_next_data", bus.resp_data, 32'h0000_007F);

        // Asynchronous reset mid-cycle while holding a result.
        @(posedge clk);
        #2;
        chk("pre_rst_valid", 32'(bus.resp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.resp_valid), 32'd0);
        chk("arst_data", bus.resp_data, 32'h0);
        chk("arst_id", 32'(bus.resp_id), 32'd0);
        chk("arst_ready0", 32'(bus.req0_ready), 32'd0);
        chk("arst_ready1", 32'(bus.req1_ready), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready0", 32'(bus.req0_ready), 32'd1);
        chk("post_rst_ready1", 32'(bus.req1_ready), 32'd0);
        step();
        @(negedge clk);
        chk("post_rst_id", 32'(bus.resp_id), 32'd0);
        chk("post_rst_valid", 32'(bus.resp_valid), 32'd1);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sign_extend_arbiter.md
Name: sign_extend_arbiter

Overview:
- Shares one variable-position sign/zero-extension datapath between two requesters.
  - Requester 0: decode stage, instruction immediates.
  - Requester 1: load unit, loaded byte/halfword data.
- Round-robin arbitration, valid/ready handshakes on both sides, one registered result stage.
- Sits between decode/LSU and the execute/writeback operand path.

Parameters:
- XLEN, 32, datapath width; all data ports are XLEN bits.
- POS_W, 3, width of the sign-position select code.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req0_valid  in  1  requester 0 has an operand
- req0_data  in  XLEN  raw value; bits above the selected position are don't-care
- req0_pos  in  POS_W  sign-position code
- req0_sext  in  1  1 = sign-extend, 0 = zero-extend
- req0_ready  out  1  requester 0 operand accepted this cycle
- req1_valid, req1_data, req1_pos, req1_sext, req1_ready  same as requester 0, for requester 1
- resp_valid  out  1  result register holds a result
- resp_data  out  XLEN  extended result
- resp_id  out  1  requester whose operand produced resp_data
- resp_ready  in  1  consumer accepts the result

Behaviour:
- Position codes:
  - 0 = bit 8 (byte)
  - 1 = bit 12 (I/S immediate)
  - 2 = bit 13 (B immediate)
  - 3 = bit 16 (halfword)
  - 4 = bit 21 (J immediate)
  - 5..7 = full width; the value passes through unchanged regardless of sext.
- Extension for position P (field = data[P-1:0]):
  - sext=1: result = data[P-1:0] with bit P-1 replicated into bits XLEN-1..P.
  - sext=0: result = data[P-1:0] with bits XLEN-1..P cleared.
- out_free = !resp_valid || resp_ready.
- Arbitration, combinational from valids and the last_grant register:
  - Only one requester valid: it gets the grant.
  - Both valid: grant goes to the requester that is NOT last_grant.
  - last_grant updates only on an accepted transfer.
- reqN_ready = grant_N && out_free. At most one ready per cycle; ready may depend on valid.
- On acceptance: resp_data/resp_id load the extended result at the next edge, and resp_valid = 1.
  - Latency: 1 cycle.
  - Throughput: 1 result per cycle when resp_ready is held high.
- No acceptance and resp_ready=1: resp_valid clears at the next edge.
- Backpressure (resp_valid=1, resp_ready=0):
  - resp_valid, resp_data and resp_id hold stable.
  - Both readies are 0.
  - last_grant is unchanged.
- Simultaneous drain and accept (resp_valid=1, resp_ready=1, new grant): the register reloads in the same cycle with no bubble.
- Requesters must hold valid and payload stable until ready. Withdrawing valid before ready is illegal; it is flagged by assertion, not handled.
- Reset (rst_n=0, any time, including mid-transfer), effective immediately:
  - resp_valid = 0, resp_data = 0, resp_id = 0.
  - last_grant = 1, so requester 0 wins the first contention.
  - No transfer is accepted while reset is asserted.
- Starvation bound: a continuously valid requester is accepted within 2 accepted transfers.

Decomposition:
- Shared package:
  - XLEN default.
  - Position-code constants: POS_BYTE, POS_IMM12, POS_IMM13, POS_HALF, POS_IMM21, POS_FULL.
  - A function mapping code to bit position.
  - The requester-id type.
- Sub-module var_sign_extend: purely combinational.
  - Inputs: data, pos, sext. Output: result.
  - Instantiated once, fed by a 2:1 mux driven by the grant.
- Arbiter, ready logic and output register stay in the top module.

Test Plan:
- Requester 0 only, data=0x0000_0800, pos=1, sext=1 -> req0_ready=1 that cycle; next cycle resp_valid=1, resp_data=0xFFFF_F800, resp_id=0.
- Requester 1 only, data=0xFFFF_FF80, pos=0: sext=0 -> resp_data=0x0000_0080; sext=1 -> 0xFFFF_FF80. Pos=5, data=0x1234_5678, either sext -> 0x1234_5678.
- Both requesters valid continuously, resp_ready=1 after reset -> resp_id sequence 0,1,0,1 with resp_valid high every cycle after the first.
- Hold resp_ready=0 for 3 cycles while both requesters are valid:
  - resp_valid/resp_data/resp_id stable, both readies 0.
  - Raise resp_ready -> the pending-grant requester is accepted the same cycle, with no bubble.
- Assert rst_n=0 asynchronously mid-cycle while resp_valid=1 -> resp_valid drops before the next edge. After release with both requesters valid -> first resp_id=0.
- Boundary bits: pos=2, data=0x0000_1000, sext=1 -> 0xFFFF_F000. Pos=4, data=0x0010_0000 -> 0xFFF0_0000. Pos=3, data=0x0000_7FFF -> 0x0000_7FFF.
